// File: rtl/i2c_eeprom_responder.sv
// I2C target modelling a 128-byte EEPROM: the first byte carries the 7-bit word address plus R/W,
// and subsequent bytes are written or read with an auto-incrementing pointer.
module i2c_eeprom_responder #(
  parameter int MEM_DEPTH   = 128,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_pulse,
  output logic       rd_pulse,
  output logic [6:0] cur_addr,
  output logic [7:0] last_wdata
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WDATA, ACK_DATA, RDATA, MACK, WAIT_STOP
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic                   rw_r;
  logic [HW-1:0]          hold_cnt_r;
  logic                   oe_next_r;
  logic                   sda_oe_r;
  logic                   busy_r;
  logic                   wr_pulse_r;
  logic                   rd_pulse_r;
  logic [6:0]             cur_addr_r;
  logic [7:0]             last_wdata_r;
  logic [7:0]             mem_r [MEM_DEPTH];

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic       mem_we_s;
  logic [7:0] mem_wdata_s;
  logic [6:0] addr_inc_s;

  assign sda        = sda_oe_r ? 1'b0 : 1'bz;
  assign busy       = busy_r;
  assign wr_pulse   = wr_pulse_r;
  assign rd_pulse   = rd_pulse_r;
  assign cur_addr   = cur_addr_r;
  assign last_wdata = last_wdata_r;

  assign scl_s       = scl_sync_r[SYNC_STAGES-1];
  assign sda_s       = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s  = scl_s & ~scl_prev_r;
  assign scl_fall_s  = ~scl_s & scl_prev_r;
  assign start_s     = scl_s & sda_prev_r & ~sda_s;
  assign stop_s      = scl_s & ~sda_prev_r & sda_s;
  assign mem_wdata_s = {shift_r[6:0], sda_s};
  assign addr_inc_s  = cur_addr_r + 7'd1;
  assign mem_we_s    = (state_r == WDATA) && scl_rise_s && (bit_cnt_r == 3'd7) && !start_s && !stop_s;

  // Input synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  // Storage array: written only when a complete data byte is committed.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[cur_addr_r] <= mem_wdata_s;
    end
  end

  // Protocol FSM; SDA changes are scheduled on SCL fall and applied after the hold countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'd0;
      rw_r         <= 1'b0;
      hold_cnt_r   <= HW'(0);
      oe_next_r    <= 1'b0;
      sda_oe_r     <= 1'b0;
      busy_r       <= 1'b0;
      wr_pulse_r   <= 1'b0;
      rd_pulse_r   <= 1'b0;
      cur_addr_r   <= 7'd0;
      last_wdata_r <= 8'd0;
    end else begin
      wr_pulse_r <= 1'b0;
      rd_pulse_r <= 1'b0;
      if (hold_cnt_r != HW'(0)) begin
        hold_cnt_r <= hold_cnt_r - HW'(1);
        if (hold_cnt_r == HW'(1)) begin
          sda_oe_r <= oe_next_r;
        end
      end

      // Bus conditions release SDA at once and cancel any pending change.
      if (stop_s) begin
        state_r    <= IDLE;
        busy_r     <= 1'b0;
        sda_oe_r   <= 1'b0;
        oe_next_r  <= 1'b0;
        hold_cnt_r <= HW'(0);
        bit_cnt_r  <= 3'd0;
      end else if (start_s) begin
        state_r    <= ADDR;
        busy_r     <= 1'b1;
        sda_oe_r   <= 1'b0;
        oe_next_r  <= 1'b0;
        hold_cnt_r <= HW'(0);
        bit_cnt_r  <= 3'd0;
      end else begin
        case (state_r)
          IDLE: begin
            busy_r <= 1'b0;
          end
          ADDR: begin
            if (scl_rise_s) begin
              shift_r <= mem_wdata_s;
              if (bit_cnt_r == 3'd7) begin
                cur_addr_r <= shift_r[6:0];
                rw_r       <= sda_s;
                bit_cnt_r  <= 3'd0;
                state_r    <= ACK_ADDR;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end
          ACK_ADDR: begin
            if (scl_fall_s) begin
              hold_cnt_r <= HW'(HOLD_CYCLES);
              if (bit_cnt_r == 3'd0) begin
                oe_next_r <= 1'b1;
                bit_cnt_r <= 3'd1;
              end else begin
                bit_cnt_r <= 3'd0;
                if (rw_r) begin
                  shift_r    <= mem_r[cur_addr_r];
                  oe_next_r  <= ~mem_r[cur_addr_r][7];
                  rd_pulse_r <= 1'b1;
                  state_r    <= RDATA;
                end else begin
                  oe_next_r <= 1'b0;
                  state_r   <= WDATA;
                end
              end
            end
          end
          WDATA: begin
            if (scl_rise_s) begin
              shift_r <= mem_wdata_s;
              if (bit_cnt_r == 3'd7) begin
                last_wdata_r <= mem_wdata_s;
                wr_pulse_r   <= 1'b1;
                cur_addr_r   <= addr_inc_s;
                bit_cnt_r    <= 3'd0;
                state_r      <= ACK_DATA;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end
          ACK_DATA: begin
            if (scl_fall_s) begin
              hold_cnt_r <= HW'(HOLD_CYCLES);
              if (bit_cnt_r == 3'd0) begin
                oe_next_r <= 1'b1;
                bit_cnt_r <= 3'd1;
              end else begin
                oe_next_r <= 1'b0;
                bit_cnt_r <= 3'd0;
                state_r   <= WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_fall_s) begin
              hold_cnt_r <= HW'(HOLD_CYCLES);
              if (bit_cnt_r == 3'd7) begin
                oe_next_r <= 1'b0;
                bit_cnt_r <= 3'd0;
                state_r   <= MACK;
              end else begin
                shift_r   <= {shift_r[6:0], 1'b0};
                oe_next_r <= ~shift_r[6];
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end
          MACK: begin
            // NACK leaves on the rise, so any fall seen here follows a master ACK.
            if (scl_rise_s) begin
              if (!sda_s) begin
                cur_addr_r <= addr_inc_s;
                shift_r    <= mem_r[addr_inc_s];
                rd_pulse_r <= 1'b1;
              end else begin
                state_r <= WAIT_STOP;
              end
            end else if (scl_fall_s) begin
              hold_cnt_r <= HW'(HOLD_CYCLES);
              oe_next_r  <= ~shift_r[7];
              bit_cnt_r  <= 3'd0;
              state_r    <= RDATA;
            end
          end
          WAIT_STOP: begin
            oe_next_r <= 1'b0;
          end
          default: begin
            state_r  <= IDLE;
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Directed bench: a behavioural I2C master drives scl/sda and checks ACKs, data and status outputs.
module tb_i2c_eeprom_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       m_oe = 1'b0;
  wire        sda_w;
  logic       busy;
  logic       wr_pulse;
  logic       rd_pulse;
  logic [6:0] cur_addr;
  logic [7:0] last_wdata;

  int n_tests = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  pullup (sda_w);
  assign sda_w = m_oe ? 1'b0 : 1'bz;

  i2c_eeprom_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl        (scl_drv),
    .sda        (sda_w),
    .busy       (busy),
    .wr_pulse   (wr_pulse),
    .rd_pulse   (rd_pulse),
    .cur_addr   (cur_addr),
    .last_wdata (last_wdata)
  );

  always #5 clk = ~clk;

  // Count strobe pulses from the responder.
  always @(posedge clk) begin
    if (wr_pulse) wr_cnt <= wr_cnt + 1;
    if (rd_pulse) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One SCL period: data set mid-low, sampled mid-high.
  task automatic bit_xfer(input logic b, output logic rb);
    wait_clk(50);
    m_oe = ~b;
    wait_clk(50);
    scl_drv = 1'b1;
    wait_clk(50);
    #1 rb = sda_w;
    wait_clk(50);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_start();
    m_oe = 1'b1;
    wait_clk(100);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(50);
    m_oe = 1'b1;
    wait_clk(50);
    scl_drv = 1'b1;
    wait_clk(100);
    m_oe = 1'b0;
    wait_clk(100);
  endtask

  task automatic byte_write(input logic [7:0] d, output logic ack_bit);
    logic dummy;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], dummy);
    bit_xfer(1'b1, ack_bit);
  endtask

  task automatic byte_read(input logic mack_bit, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(mack_bit, dummy);
  endtask

  initial begin
    logic       ack;
    logic       rb;
    logic [7:0] rd;

    // Test 1: reset state, held and released.
    wait_clk(5);
    #1;
    check("rst_sda", 32'(sda_w), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_addr", 32'(cur_addr), 32'h0);
    check("rst_lwd", 32'(last_wdata), 32'h0);
    rst_n = 1'b1;
    wait_clk(10);
    #1;
    check("post_rst_sda", 32'(sda_w), 32'h1);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_pulses", 32'(wr_cnt + rd_cnt), 32'h0);

    // Test 2: write 0xA5 to 0x12.
    i2c_start();
    byte_write(8'h24, ack);
    check("t2_addr_ack", 32'(ack), 32'h0);
    byte_write(8'hA5, ack);
    check("t2_data_ack", 32'(ack), 32'h0);
    check("t2_busy", 32'(busy), 32'h1);
    i2c_stop();
    check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t2_lwd", 32'(last_wdata), 32'hA5);
    check("t2_addr", 32'(cur_addr), 32'h13);
    check("t2_busy_end", 32'(busy), 32'h0);

    // Test 3: single read of 0x12 ending with NACK.
    i2c_start();
    byte_write(8'h25, ack);
    check("t3_addr_ack", 32'(ack), 32'h0);
    byte_read(1'b1, rd);
    check("t3_rdata", 32'(rd), 32'hA5);
    check("t3_rd_cnt", 32'(rd_cnt), 32'd1);
    wait_clk(50);
    #1;
    check("t3_sda_rel", 32'(sda_w), 32'h1);
    check("t3_busy_wait", 32'(busy), 32'h1);
    check("t3_addr", 32'(cur_addr), 32'h12);
    i2c_stop();
    check("t3_busy_end", 32'(busy), 32'h0);

    // Test 4: three-byte write from 0x7F wrapping to 0x01.
    i2c_start();
    byte_write(8'hFE, ack);
    check("t4_addr_ack", 32'(ack), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      byte_write(8'(i), ack);
      check("t4_data_ack", 32'(ack), 32'h0);
    end
    i2c_stop();
    check("t4_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t4_addr", 32'(cur_addr), 32'h02);
    check("t4_lwd", 32'(last_wdata), 32'h03);

    // Test 5: sequential read from 0x7F with ACK, ACK, NACK.
    i2c_start();
    byte_write(8'hFF, ack);
    check("t5_addr_ack", 32'(ack), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      byte_read((i == 3) ? 1'b1 : 1'b0, rd);
      check("t5_rdata", 32'(rd), 32'(i));
    end
    check("t5_rd_cnt", 32'(rd_cnt), 32'd4);
    check("t5_addr", 32'(cur_addr), 32'h01);
    check("t5_busy_wait", 32'(busy), 32'h1);
    i2c_stop();
    check("t5_busy_end", 32'(busy), 32'h0);

    // Test 6a: STOP after four data bits discards the partial byte.
    i2c_start();
    byte_write(8'h24, ack);
    check("t6a_addr_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b0, rb);
    i2c_stop();
    check("t6a_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t6a_lwd", 32'(last_wdata), 32'h03);
    check("t6a_addr", 32'(cur_addr), 32'h12);
    check("t6a_busy", 32'(busy), 32'h0);

    // Test 6b: reset while a 0 bit of 0xA5 is being driven.
    i2c_start();
    byte_write(8'h25, ack);
    check("t6b_addr_ack", 32'(ack), 32'h0);
    bit_xfer(1'b1, rb);
    check("t6b_bit7", 32'(rb), 32'h1);
    wait_clk(50);
    #1;
    check("t6b_bit6_driven", 32'(sda_w), 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6b_rst_sda", 32'(sda_w), 32'h1);
    check("t6b_rst_busy", 32'(busy), 32'h0);
    check("t6b_rst_addr", 32'(cur_addr), 32'h0);
    wait_clk(10);
    m_oe = 1'b0;
    scl_drv = 1'b1;
    wait_clk(10);
    rst_n = 1'b1;
    wait_clk(20);
    #1;
    check("t6b_idle_busy", 32'(busy), 32'h0);

    // Memory at 0x12 must be untouched by both aborted transfers.
    i2c_start();
    byte_write(8'h25, ack);
    check("t6_rb_ack", 32'(ack), 32'h0);
    byte_read(1'b1, rd);
    check("t6_rb_data", 32'(rd), 32'hA5);
    i2c_stop();
    check("t6_rd_cnt", 32'(rd_cnt), 32'd6);
    check("t6_wr_cnt", 32'(wr_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_responder.md
Name: i2c_eeprom_responder

Overview:
I2C target (responder) that models a 128-byte byte-addressable EEPROM. It is the bus-side counterpart of i2c_eeprom_controller. It decodes START/STOP, treats the 7-bit field of the first byte as the word address, and takes R/W from bit 0. It ACKs the address, then either stores incoming data bytes or returns stored bytes, auto-incrementing the address. It sits on the same scl/sda pair as the controller, for loopback on-board and in benches.

Parameters:
MEM_DEPTH, 128, number of bytes; the address field is 7 bits, so addresses wrap modulo 128.
SYNC_STAGES, 2, flop stages on the scl/sda inputs.
HOLD_CYCLES, 20, clk cycles after a detected SCL fall before sda_oe changes (SDA hold time; 200 ns at 100 MHz).

Ports:
clk  input  1  system clock, 100 MHz in top.
rst_n  input  1  asynchronous reset, active-low.
scl  input  1  I2C clock from the controller; the responder never stretches it.
sda  inout  1  I2C data, open-drain: driven 0 when sda_oe=1, else high-Z (external pull-up).
busy  output  1  high from START until STOP or return to IDLE.
wr_pulse  output  1  one-clk pulse when a data byte is committed to memory.
rd_pulse  output  1  one-clk pulse when a byte is loaded for transmission.
cur_addr  output  7  current word address pointer.
last_wdata  output  8  last byte committed to memory.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sda_oe=0, busy=0, wr_pulse=0, rd_pulse=0, cur_addr=0, last_wdata=0, bit counter=0, synchronizers forced to 1. Memory contents are not reset.
- Inputs pass through SYNC_STAGES flops, plus one history flop for edge detection.
- START = SDA fall while SCL=1. STOP = SDA rise while SCL=1. Both take priority over bit processing in the same cycle.
- Data bits are sampled on detected SCL rise, MSB first.
- sda_oe changes only HOLD_CYCLES clks after a detected SCL fall (hold counter).
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits; after the 8th rise, cur_addr=bits[7:1], rw=bit0 -> ACK_ADDR.
  - ACK_ADDR: drive 0 (sda_oe=1) for the 9th SCL period. On the 9th fall: if rw=0 -> WDATA (release). If rw=1 -> load mem[cur_addr], rd_pulse, -> RDATA.
  - WDATA: shift 8 bits. After the 8th rise: mem[cur_addr]<=byte, last_wdata<=byte, wr_pulse, cur_addr<=cur_addr+1 (127 wraps to 0) -> ACK_DATA.
  - ACK_DATA: drive 0 for the 9th period, then -> WDATA.
  - RDATA: drive the bit after each fall (sda_oe = ~bit); bit 7 is driven after the ACK_ADDR/MACK fall. After the 8th bit's fall, release -> MACK.
  - MACK: sample SDA on the 9th rise. If 0 (ACK): cur_addr+1, load next byte, rd_pulse, -> RDATA on the fall. If 1 (NACK): -> WAIT_STOP, SDA released.
  - WAIT_STOP: sda_oe=0; ignore bits until STOP or START.
- STOP in any state -> IDLE, sda_oe=0, busy=0. A partially shifted write byte is discarded (no memory write).
- START in any non-IDLE state (repeated start) -> ADDR, bit counter cleared, sda_oe=0; cur_addr is kept until the new address byte completes.
- Never drives SDA during a START/STOP condition: sda_oe may be 1 only in ACK_ADDR, ACK_DATA, or on 0-bits of RDATA.
- Read pointer increments only on master ACK; write pointer increments only on a committed byte.
- rst_n asserted mid-transfer releases SDA immediately (async).

Test Plan:
1. Reset with sda/scl idle high -> sda high-Z, busy=0, cur_addr=0; then release rst_n -> outputs unchanged.
2. Controller write wdata=0xA5 to addr=0x12 -> ACK on address and data bits, wr_pulse once, last_wdata=0xA5, cur_addr=0x13, busy falls after STOP.
3. Controller read addr=0x12 after test 2 -> rd_pulse once, controller rdata=0xA5 on rdata_led, responder releases SDA at MACK (NACK) and returns to IDLE on STOP.
4. Bench master writes three bytes 0x01,0x02,0x03 starting at 0x7F -> mem[0x7F]=0x01, mem[0x00]=0x02, mem[0x01]=0x03, cur_addr=0x02 (wrap).
5. Sequential read from 0x7F with ACK, ACK, NACK -> returns 0x01,0x02,0x03, three rd_pulses, then WAIT_STOP.
6. STOP after 4 data bits of a write; separately, rst_n low during RDATA with a 0 bit driven -> no wr_pulse and memory unchanged; sda released within the reset assertion, state IDLE.
